// File: rtl/riscv_merger_if.sv
// AXI-Stream bundle used on all three riscv_merger stream ports.
// master drives the beat and samples tready; slave does the reverse.
interface riscv_merger_if #(
  parameter int DW = 512,
  parameter int UW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [UW-1:0]   tuser;
  logic            tvalid;
  logic            tlast;
  logic            tready;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/riscv_merger.sv
// riscv_merger: packet-atomic 2:1 AXI-Stream merger (data path + RISC-V core -> MAC/host).
// Once a packet starts, its source keeps the grant until tlast; the other input is stalled.
// Output stage is a single register slice; per-source completed-packet counters.
// Build option: RISCV_PRIO_EN -- ties in IDLE always go to the RISC-V input instead of
// alternating with the previous winner.
module riscv_merger #(
  parameter int C_S_AXIS_DATA_WIDTH  = 512,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int CNT_WIDTH            = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_merger_if.slave        s_axis,
  riscv_merger_if.slave        c_s_axis,
  riscv_merger_if.master       m_axis,
  output logic [CNT_WIDTH-1:0] data_pkt_cnt,
  output logic [CNT_WIDTH-1:0] ctl_pkt_cnt
);
  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  localparam logic GNT_DATA = 1'b0;
  localparam logic GNT_CTL  = 1'b1;

  typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTL} state_t;

  state_t r_state, w_state_nxt;

  logic [DW-1:0] r_m_tdata;
  logic [KW-1:0] r_m_tkeep;
  logic [UW-1:0] r_m_tuser;
  logic          r_m_tvalid;
  logic          r_m_tlast;
  logic [CNT_WIDTH-1:0] r_data_cnt, r_ctl_cnt;

  logic w_out_free, w_gnt_data, w_gnt_ctl, w_tie_data;
  logic w_s_xfer, w_c_xfer;

  // Output slice can take a beat when empty or when its beat leaves this cycle
  assign w_out_free = !r_m_tvalid || m_axis.tready;

`ifdef RISCV_PRIO_EN
  // Strict priority: the RISC-V input wins every tie
  assign w_tie_data = 1'b0;
`else
  logic r_last_grant;

  // Remember who sent the last accepted beat; starts at CTL so the first tie goes to DATA
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_last_grant <= GNT_CTL;
    else if (w_s_xfer) r_last_grant <= GNT_DATA;
    else if (w_c_xfer) r_last_grant <= GNT_CTL;
  end

  // Round robin: a tie goes to whoever did not win last time
  assign w_tie_data = (r_last_grant == GNT_CTL);
`endif

  // Arbitration: free choice only in IDLE, locked to the packet owner otherwise
  always_comb begin
    w_gnt_data = 1'b0;
    w_gnt_ctl  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (s_axis.tvalid && c_s_axis.tvalid) begin
          w_gnt_data = w_tie_data;
          w_gnt_ctl  = !w_tie_data;
        end else begin
          w_gnt_data = s_axis.tvalid;
          w_gnt_ctl  = c_s_axis.tvalid;
        end
      end
      FWD_DATA: w_gnt_data = 1'b1;
      FWD_CTL:  w_gnt_ctl  = 1'b1;
      default: ;
    endcase
  end

  // Ready is held low during reset so nothing is accepted while the slice is being cleared
  assign s_axis.tready   = !reset && w_out_free && w_gnt_data;
  assign c_s_axis.tready = !reset && w_out_free && w_gnt_ctl;

  assign w_s_xfer = s_axis.tvalid   && s_axis.tready;
  assign w_c_xfer = c_s_axis.tvalid && c_s_axis.tready;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: enter FWD_x on a non-last first beat, return to IDLE on the owner's tlast
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_s_xfer && !s_axis.tlast)        w_state_nxt = FWD_DATA;
        else if (w_c_xfer && !c_s_axis.tlast) w_state_nxt = FWD_CTL;
      end
      FWD_DATA: if (w_s_xfer && s_axis.tlast)   w_state_nxt = IDLE;
      FWD_CTL:  if (w_c_xfer && c_s_axis.tlast) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Output slice: load the accepted beat bit-exact, drop valid once consumed with nothing new
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tuser  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else if (w_s_xfer) begin
      r_m_tdata  <= s_axis.tdata;
      r_m_tkeep  <= s_axis.tkeep;
      r_m_tuser  <= s_axis.tuser;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= s_axis.tlast;
    end else if (w_c_xfer) begin
      r_m_tdata  <= c_s_axis.tdata;
      r_m_tkeep  <= c_s_axis.tkeep;
      r_m_tuser  <= c_s_axis.tuser;
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= c_s_axis.tlast;
    end else if (m_axis.tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Packet counters: bump on each accepted tlast, natural wrap to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_cnt <= '0;
      r_ctl_cnt  <= '0;
    end else begin
      if (w_s_xfer && s_axis.tlast)   r_data_cnt <= r_data_cnt + 1'b1;
      if (w_c_xfer && c_s_axis.tlast) r_ctl_cnt  <= r_ctl_cnt + 1'b1;
    end
  end

  assign m_axis.tdata  = r_m_tdata;
  assign m_axis.tkeep  = r_m_tkeep;
  assign m_axis.tuser  = r_m_tuser;
  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tlast  = r_m_tlast;
  assign data_pkt_cnt  = r_data_cnt;
  assign ctl_pkt_cnt   = r_ctl_cnt;
endmodule

// File: tb/tb_riscv_merger.sv
// tb_riscv_merger: directed bench for riscv_merger (narrow widths, 4-bit counters).
// Inputs change on the falling edge; everything is sampled 4 ns later, before the rising edge.
module tb_riscv_merger;
  localparam int DW = 32;
  localparam int UW = 8;
  localparam int KW = DW / 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  riscv_merger_if #(.DW(DW), .UW(UW)) s_if ();
  riscv_merger_if #(.DW(DW), .UW(UW)) c_if ();
  riscv_merger_if #(.DW(DW), .UW(UW)) m_if ();

  logic [CW-1:0] data_cnt, ctl_cnt;

  riscv_merger #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .CNT_WIDTH           (CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_axis      (s_if),
    .c_s_axis    (c_if),
    .m_axis      (m_if),
    .data_pkt_cnt(data_cnt),
    .ctl_pkt_cnt (ctl_cnt)
  );

  typedef struct packed {
    logic          last;
    logic [UW-1:0] user;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    acc_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    first_in_edge = 0;
  bit    ctl_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Beat contents encode source/packet/beat so order and interleave errors show up.
  // tkeep = beat index, so every first beat carries tkeep==0.
  function automatic beat_t mk_beat(input int src, input int pkt, input int b, input bit last);
    beat_t t;
    t.data = {4'hA, 4'(src), 8'(pkt), 8'(b), 8'h5A};
    t.keep = KW'(b);
    t.user = {1'(src), 3'(pkt), 4'(b)};
    t.last = last;
    return t;
  endfunction

  task automatic drive(input int src, input bit v, input beat_t t);
    if (src == 0) begin
      s_if.tvalid = v; s_if.tdata = t.data; s_if.tkeep = t.keep;
      s_if.tuser = t.user; s_if.tlast = t.last;
    end else begin
      c_if.tvalid = v; c_if.tdata = t.data; c_if.tkeep = t.keep;
      c_if.tuser = t.user; c_if.tlast = t.last;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the last handshake.
  // gap_at: beat index after which tvalid drops for gap_len cycles (-1 = none).
  task automatic send_pkt(input int src, input int pkt, input int nb,
                          input int gap_at, input int gap_len);
    for (int b = 0; b < nb; b++) begin
      bit hs;
      int k;
      drive(src, 1'b1, mk_beat(src, pkt, b, b == nb - 1));
      hs = 1'b0;
      k = 0;
      while (!hs) begin
        #4;
        hs = (src == 0) ? (s_if.tvalid && s_if.tready) : (c_if.tvalid && c_if.tready);
        if (hs && b == 0) first_in_edge = cyc + 1;
        @(negedge clk);
        k++;
        if (!hs && k > 200) begin
          chk("hs_timeout", 64'(k), 64'(0));
          drive(src, 1'b0, mk_beat(src, pkt, b, 1'b0));
          return;
        end
      end
      if (b == gap_at) begin
        drive(src, 1'b0, mk_beat(src, pkt, b, 1'b0));
        repeat (gap_len) @(negedge clk);
      end
    end
    drive(src, 1'b0, mk_beat(src, pkt, 0, 1'b0));
  endtask

  task automatic push_pkt(input int src, input int pkt, input int nb);
    for (int b = 0; b < nb; b++) exp_q.push_back(mk_beat(src, pkt, b, b == nb - 1));
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Output monitor: accepted beats against the expected queue, and stability while stalled
  initial begin : mon
    beat_t cur, prev;
    bit    stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      #4;
      if (reset) begin
        stall = 1'b0;
      end else begin
        cur = {m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata};
        if (stall) chk("hold", 64'({cur, m_if.tvalid}), 64'({prev, 1'b1}));
        if (m_if.tvalid && m_if.tready) begin
          acc_q.push_back(cyc + 1);
          if (exp_q.size() == 0) chk("extra_beat", 64'(exp_q.size()), 64'(1));
          else chk("beat", 64'(cur), 64'(exp_q.pop_front()));
        end
        stall = m_if.tvalid && !m_if.tready;
        prev  = cur;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    m_if.tready = 1'b1;
    reset = 1'b1;

    // Reset state, with both inputs requesting so ready gating is visible
    @(negedge clk);
    drive(0, 1'b1, mk_beat(0, 0, 0, 1'b1));
    drive(1, 1'b1, mk_beat(1, 0, 0, 1'b1));
    #1;
    chk("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    chk("rst_s_tready", 64'(s_if.tready), 64'(0));
    chk("rst_c_tready", 64'(c_if.tready), 64'(0));
    chk("rst_cnts", 64'({data_cnt, ctl_cnt}), 64'(0));
    @(negedge clk);
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Data only: 3-beat packet, output beats on the three edges after the first input edge
    acc_q.delete();
    push_pkt(0, 1, 3);
    send_pkt(0, 1, 3, -1, 0);
    wait_drain();
    chk("lat_n", 64'(acc_q.size()), 64'(3));
    for (int i = 0; i < 3 && i < acc_q.size(); i++)
      chk("lat_edge", 64'(acc_q[i] - first_in_edge), 64'(i + 1));
    chk("t2_data_cnt", 64'(data_cnt), 64'(1));
    chk("t2_ctl_cnt", 64'(ctl_cnt), 64'(0));

    // Reset mid-packet: first beat parked in the stalled output slice, then async reset
    @(negedge clk);
    m_if.tready = 1'b0;
    drive(0, 1'b1, mk_beat(0, 9, 0, 1'b0));
    @(negedge clk);
    chk("t1_pre_tvalid", 64'(m_if.tvalid), 64'(1));
    chk("t1_pre_cnt", 64'(data_cnt), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("t1_m_out", 64'({m_if.tvalid, m_if.tlast, m_if.tuser, m_if.tkeep, m_if.tdata}), 64'(0));
    chk("t1_treadys", 64'({s_if.tready, c_if.tready}), 64'(0));
    chk("t1_cnts", 64'({data_cnt, ctl_cnt}), 64'(0));
    drive(0, 1'b0, '0);
    @(negedge clk);
    reset = 1'b0;
    m_if.tready = 1'b1;
    @(negedge clk);

    // Contention: two 4-beat packets per source, both starting together
`ifdef RISCV_PRIO_EN
    push_pkt(1, 1, 4); push_pkt(1, 2, 4); push_pkt(0, 1, 4); push_pkt(0, 2, 4);
`else
    push_pkt(0, 1, 4); push_pkt(1, 1, 4); push_pkt(0, 2, 4); push_pkt(1, 2, 4);
`endif
    fork
      begin send_pkt(0, 1, 4, -1, 0); send_pkt(0, 2, 4, -1, 0); end
      begin send_pkt(1, 1, 4, -1, 0); send_pkt(1, 2, 4, -1, 0); end
    join
    wait_drain();
    chk("t3_data_cnt", 64'(data_cnt), 64'(2));
    chk("t3_ctl_cnt", 64'(ctl_cnt), 64'(2));

    // Lock: CTL packet with a 3-cycle tvalid gap; data waits the whole time
    push_pkt(1, 3, 4);
    push_pkt(0, 3, 1);
    ctl_done = 1'b0;
    fork
      begin send_pkt(1, 3, 4, 0, 3); ctl_done = 1'b1; end
      begin repeat (2) @(negedge clk); send_pkt(0, 3, 1, -1, 0); end
      begin
        repeat (2) @(negedge clk);
        for (int k = 0; k < 50; k++) begin
          #4;
          if (ctl_done) break;
          chk("lock_s_tready", 64'(s_if.tready), 64'(0));
          @(negedge clk);
        end
      end
    join
    wait_drain();
    chk("t5_data_cnt", 64'(data_cnt), 64'(3));
    chk("t5_ctl_cnt", 64'(ctl_cnt), 64'(3));

    // Backpressure: m_axis_tready toggles 1,0,1,0... across a 5-beat packet
    push_pkt(0, 4, 5);
    fork
      send_pkt(0, 4, 5, -1, 0);
      begin
        for (int i = 0; i < 20; i++) begin
          m_if.tready = (i % 2 == 0);
          @(negedge clk);
        end
        m_if.tready = 1'b1;
      end
    join
    wait_drain();
    chk("t4_data_cnt", 64'(data_cnt), 64'(4));

    // Counter wrap: 17 single-beat data packets on a 4-bit counter
    pulse_reset();
    @(negedge clk);
    chk("t6_cnt0", 64'(data_cnt), 64'(0));
    for (int p = 0; p < 17; p++) begin
      push_pkt(0, p, 1);
      send_pkt(0, p, 1, -1, 0);
      if (p == 14) chk("t6_cnt_max", 64'(data_cnt), 64'(15));
      if (p == 15) chk("t6_cnt_wrap", 64'(data_cnt), 64'(0));
    end
    wait_drain();
    chk("t6_data_cnt", 64'(data_cnt), 64'(1));
    chk("t6_ctl_cnt", 64'(ctl_cnt), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
